controlador_cruzamento: RTL
===========================

Name: controlador_cruzamento

Overview:
- Scheduler for one intersection with three requesters: main road (default owner), side road (vehicle sensor) and pedestrian crossing (push button).
- Grants the crossing area to one requester at a time through a Moore FSM with per-state cycle timers.
- Latches requests and arbitrates side versus pedestrian round-robin.
- Drives the lamp outputs of all three signal heads directly.

Parameters:
- CW, 8: width of the in-state cycle counter.
- T_MIN_VERDE, 4: minimum main-green cycles before any request is served.
- T_AMARELO, 2: yellow duration in cycles, used for both roads.
- T_TODOS_VERM, 1: all-red clearance cycles.
- T_MIN_SEC, 2: minimum side-green cycles.
- T_MAX_SEC, 6: maximum side-green cycles.
- T_PEDESTRE, 4: pedestrian walk cycles.
- Constraint: every T_* is ≥1 and <2^CW; T_MIN_SEC ≤ T_MAX_SEC.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- sensor_secundaria, input, 1: side-road vehicle present, level.
- botao_pedestre, input, 1: pedestrian request, sampled each edge.
- principal_vm / principal_am / principal_vd, output, 1 each: main road red / yellow / green.
- secundaria_vm / secundaria_am / secundaria_vd, output, 1 each: side road red / yellow / green.
- ped_vm / ped_vd, output, 1 each: pedestrian red / green.
- ped_pend, output, 1: latched pedestrian request (waiting indicator).
- sec_pend, output, 1: latched side-road request.
- estado_dbg, output, 3: current state code.

Behaviour:
- States and codes: VERDE_P=0, AMARELO_P=1, VERMELHO_TOTAL=2, VERDE_S=3, AMARELO_S=4, PEDESTRE=5. Codes 6 and 7 are illegal and go to VERDE_P on the next edge.
- tempo (CW bits): cleared on every state change, otherwise +1 per cycle.
- In VERDE_P only, tempo saturates at 2^CW-1 and never wraps.
- Transitions (registered; conditions use registered pend bits only):
  - VERDE_P -> AMARELO_P when tempo ≥ T_MIN_VERDE-1 and (ped_pend | sec_pend).
  - AMARELO_P -> VERMELHO_TOTAL when tempo == T_AMARELO-1.
  - VERMELHO_TOTAL, when tempo == T_TODOS_VERM-1: grant PEDESTRE if ped_pend and (!sec_pend or ultimo==SEC); otherwise grant VERDE_S.
  - VERDE_S -> AMARELO_S when (tempo ≥ T_MIN_SEC-1 and !sensor_secundaria) or tempo == T_MAX_SEC-1.
  - AMARELO_S -> VERDE_P when tempo == T_AMARELO-1.
  - PEDESTRE -> VERDE_P when tempo == T_PEDESTRE-1.
- Fairness register ultimo:
  - Set to SEC on entry to VERDE_S, set to PED on entry to PEDESTRE.
  - Reset value is SEC, so the pedestrian wins the first tie.
- Request latches:
  - ped_pend is set by botao_pedestre in any state except PEDESTRE, where the button is ignored. It is cleared on the edge entering PEDESTRE.
  - sec_pend is set by sensor_secundaria in any state except VERDE_S. It is cleared on the edge entering VERDE_S.
  - Set and clear on the same edge: clear wins. The entering state blocks its own set anyway.
- The requester that loses arbitration stays pending. It is served only after main road returns and a fresh T_MIN_VERDE elapses, so main road cannot starve.
- Outputs are Moore, decoded from the registered state; exactly one lamp per head is on:
  - VERDE_P: principal_vd, secundaria_vm, ped_vm.
  - AMARELO_P: principal_am, secundaria_vm, ped_vm.
  - VERMELHO_TOTAL: principal_vm, secundaria_vm, ped_vm.
  - VERDE_S: principal_vm, secundaria_vd, ped_vm.
  - AMARELO_S: principal_vm, secundaria_am, ped_vm.
  - PEDESTRE: principal_vm, secundaria_vm, ped_vd.
- Reset (reset=0, including mid-operation): state VERDE_P, tempo=0, ped_pend=0, sec_pend=0, ultimo=SEC. Outputs immediately become principal_vd=1, secundaria_vm=1, ped_vm=1, estado_dbg=0, all others 0.
- Latency: a request sampled at edge k sets its pend bit after edge k. The earliest VERDE_P exit is at edge max(k+1, the edge where tempo reaches T_MIN_VERDE-1).

Test Plan:
- Reset release, then a one-cycle botao_pedestre at the first edge. Required: VERDE_P for 4 cycles, AMARELO_P 2, VERMELHO_TOTAL 1, PEDESTRE 4 (ped_vd=1, principal_vm=1), then VERDE_P. ped_pend stays 1 until PEDESTRE entry.
- Button and sensor together, sensor held. Required: PEDESTRE served first. sec_pend stays 1; then VERDE_P for 4 cycles, yellow, all-red, VERDE_S for 6 cycles (T_MAX_SEC), AMARELO_S 2, VERDE_P.
- One-cycle sensor pulse only. Required: VERDE_S lasts exactly 2 cycles (T_MIN_SEC), then AMARELO_S.
- Second round with both pending and ultimo==PED. Required: VERDE_S granted; ped_pend stays 1.
- botao_pedestre held high throughout PEDESTRE. Required: ped_pend=0 during PEDESTRE; it returns to 1 one cycle after VERDE_P entry if the button is still high.
- Assert reset=0 mid-AMARELO_P. Required: same-cycle return to principal_vd=1, pend bits 0, estado_dbg=0. No transition until a new request plus 4 cycles.
- Idle 300 cycles with CW=8. Required: tempo saturates at 255 with no wrap; a request then exits VERDE_P on the next edge after its pend bit sets.

Source files
------------

// File: rtl/controlador_cruzamento.sv
// -----------------------------------------------------------------------------
// controlador_cruzamento
//
// Traffic scheduler for one intersection with three requesters:
//   - main road (default owner of the crossing area),
//   - side road (vehicle sensor, level input),
//   - pedestrian crossing (push button, sampled every edge).
//
// A Moore FSM grants the crossing area to one requester at a time. Each state
// has its own cycle timer (tempo), which is cleared on every state change.
// Side-road and pedestrian requests are latched. When both are waiting they
// are served round-robin through the fairness bit 'ultimo'.
//
// Ports:
//   clk                : single clock; all state updates on the rising edge
//   reset              : asynchronous, active-low reset
//   sensor_secundaria  : side-road vehicle present (level)
//   botao_pedestre     : pedestrian request (sampled each edge)
//   principal_vm/am/vd : main road red / yellow / green
//   secundaria_vm/am/vd: side road red / yellow / green
//   ped_vm / ped_vd    : pedestrian red / green
//   ped_pend           : latched pedestrian request (waiting indicator)
//   sec_pend           : latched side-road request
//   estado_dbg         : current state code
// -----------------------------------------------------------------------------
module controlador_cruzamento #(
    parameter int CW           = 8,
    parameter int T_MIN_VERDE  = 4,
    parameter int T_AMARELO    = 2,
    parameter int T_TODOS_VERM = 1,
    parameter int T_MIN_SEC    = 2,
    parameter int T_MAX_SEC    = 6,
    parameter int T_PEDESTRE   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_secundaria,
    input  logic       botao_pedestre,
    output logic       principal_vm,
    output logic       principal_am,
    output logic       principal_vd,
    output logic       secundaria_vm,
    output logic       secundaria_am,
    output logic       secundaria_vd,
    output logic       ped_vm,
    output logic       ped_vd,
    output logic       ped_pend,
    output logic       sec_pend,
    output logic [2:0] estado_dbg
);

    // State codes (also exported on estado_dbg)
    localparam logic [2:0] VERDE_P        = 3'd0;
    localparam logic [2:0] AMARELO_P      = 3'd1;
    localparam logic [2:0] VERMELHO_TOTAL = 3'd2;
    localparam logic [2:0] VERDE_S        = 3'd3;
    localparam logic [2:0] AMARELO_S      = 3'd4;
    localparam logic [2:0] PEDESTRE       = 3'd5;

    // Fairness: which requester was served most recently
    localparam logic ULT_PED = 1'b0;
    localparam logic ULT_SEC = 1'b1;

    // Timer thresholds: tempo counts from 0, so a state lasting N cycles
    // leaves on the edge where tempo == N-1.
    localparam logic [CW-1:0] LIM_MIN_VERDE  = CW'(T_MIN_VERDE - 1);
    localparam logic [CW-1:0] LIM_AMARELO    = CW'(T_AMARELO - 1);
    localparam logic [CW-1:0] LIM_TODOS_VERM = CW'(T_TODOS_VERM - 1);
    localparam logic [CW-1:0] LIM_MIN_SEC    = CW'(T_MIN_SEC - 1);
    localparam logic [CW-1:0] LIM_MAX_SEC    = CW'(T_MAX_SEC - 1);
    localparam logic [CW-1:0] LIM_PEDESTRE   = CW'(T_PEDESTRE - 1);
    localparam logic [CW-1:0] TEMPO_MAX      = {CW{1'b1}};

    logic [2:0]    estado_q, estado_d;
    logic [CW-1:0] tempo_q, tempo_d;
    logic          ped_pend_q, ped_pend_d;
    logic          sec_pend_q, sec_pend_d;
    logic          ultimo_q, ultimo_d;

    logic muda;       // state changes on this edge
    logic entra_ped;  // entering PEDESTRE on this edge
    logic entra_sec;  // entering VERDE_S on this edge

    // ------------------------------------------------------------------
    // Next-state logic. Only the registered pend bits steer transitions,
    // so a request always costs at least one edge before it is honoured.
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            VERDE_P: begin
                if ((tempo_q >= LIM_MIN_VERDE) && (ped_pend_q || sec_pend_q))
                    estado_d = AMARELO_P;
            end
            AMARELO_P: begin
                if (tempo_q == LIM_AMARELO)
                    estado_d = VERMELHO_TOTAL;
            end
            VERMELHO_TOTAL: begin
                // Pedestrian wins if alone, or on a tie when the side road
                // was the last one served.
                if (tempo_q == LIM_TODOS_VERM) begin
                    if (ped_pend_q && (!sec_pend_q || (ultimo_q == ULT_SEC)))
                        estado_d = PEDESTRE;
                    else
                        estado_d = VERDE_S;
                end
            end
            VERDE_S: begin
                // Leave early once the minimum is met and the road is empty;
                // never exceed the maximum even with traffic present.
                if (((tempo_q >= LIM_MIN_SEC) && !sensor_secundaria) ||
                    (tempo_q == LIM_MAX_SEC))
                    estado_d = AMARELO_S;
            end
            AMARELO_S: begin
                if (tempo_q == LIM_AMARELO)
                    estado_d = VERDE_P;
            end
            PEDESTRE: begin
                if (tempo_q == LIM_PEDESTRE)
                    estado_d = VERDE_P;
            end
            default: estado_d = VERDE_P;  // illegal codes 6/7 recover
        endcase
    end

    assign muda      = (estado_d != estado_q);
    assign entra_ped = muda && (estado_d == PEDESTRE);
    assign entra_sec = muda && (estado_d == VERDE_S);

    // ------------------------------------------------------------------
    // Timer, request latches and fairness bit
    // ------------------------------------------------------------------
    always_comb begin
        // Main green may idle indefinitely, so its timer saturates rather
        // than wrapping back below the minimum-green threshold. The other
        // states always leave before the counter could overflow.
        if (muda)
            tempo_d = '0;
        else if ((estado_q == VERDE_P) && (tempo_q == TEMPO_MAX))
            tempo_d = tempo_q;
        else
            tempo_d = tempo_q + 1'b1;

        // Clear on entry wins over a set on the same edge; the state being
        // served also ignores its own request input.
        if (entra_ped)
            ped_pend_d = 1'b0;
        else
            ped_pend_d = ped_pend_q | (botao_pedestre && (estado_q != PEDESTRE));

        if (entra_sec)
            sec_pend_d = 1'b0;
        else
            sec_pend_d = sec_pend_q | (sensor_secundaria && (estado_q != VERDE_S));

        ultimo_d = ultimo_q;
        if (entra_sec)
            ultimo_d = ULT_SEC;
        else if (entra_ped)
            ultimo_d = ULT_PED;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= VERDE_P;
            tempo_q    <= '0;
            ped_pend_q <= 1'b0;
            sec_pend_q <= 1'b0;
            ultimo_q   <= ULT_SEC;  // pedestrian wins the first tie
        end else begin
            estado_q   <= estado_d;
            tempo_q    <= tempo_d;
            ped_pend_q <= ped_pend_d;
            sec_pend_q <= sec_pend_d;
            ultimo_q   <= ultimo_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore lamp decode: exactly one lamp per head is lit.
    // ------------------------------------------------------------------
    always_comb begin
        principal_vm  = 1'b0;
        principal_am  = 1'b0;
        principal_vd  = 1'b0;
        secundaria_vm = 1'b0;
        secundaria_am = 1'b0;
        secundaria_vd = 1'b0;
        ped_vm        = 1'b0;
        ped_vd        = 1'b0;
        case (estado_q)
            VERDE_P: begin
                principal_vd  = 1'b1;
                secundaria_vm = 1'b1;
                ped_vm        = 1'b1;
            end
            AMARELO_P: begin
                principal_am  = 1'b1;
                secundaria_vm = 1'b1;
                ped_vm        = 1'b1;
            end
            VERDE_S: begin
                principal_vm  = 1'b1;
                secundaria_vd = 1'b1;
                ped_vm        = 1'b1;
            end
            AMARELO_S: begin
                principal_vm  = 1'b1;
                secundaria_am = 1'b1;
                ped_vm        = 1'b1;
            end
            PEDESTRE: begin
                principal_vm  = 1'b1;
                secundaria_vm = 1'b1;
                ped_vd        = 1'b1;
            end
            default: begin
                // VERMELHO_TOTAL, and the safe all-red view of illegal codes
                principal_vm  = 1'b1;
                secundaria_vm = 1'b1;
                ped_vm        = 1'b1;
            end
        endcase
    end

    assign ped_pend   = ped_pend_q;
    assign sec_pend   = sec_pend_q;
    assign estado_dbg = estado_q;

endmodule
